vpi_pattern_src: RTL and testbench

- Source side of the public-signal compare protocol. In the existing flow, the C/VPI side writes `sig`/`rfr` and pulses `check`, and the HDL compares them.
- This block reverses that direction. HDL generates a pseudo-random `LENGTH`-bit value and publishes it in public signals `sig` and `rfr` (`/*verilator public_flat_rd*/`).
- It then holds the value under a `valid`/`ack` handshake until a VPI reader has sampled and compared it. The reader drives `ack` through a `public_flat_rw` wrapper.
- One instance per `LENGTH` in a generate loop (1..128), mirroring the existing array test.

---
 rtl/vpi_pattern_src_pkg.sv | 25 ++
 rtl/vpi_pattern_src_if.sv | 26 ++
 rtl/vpi_pattern_src_lfsr.sv | 28 ++
 rtl/vpi_pattern_src.sv | 115 +++++++++++
 tb/tb_vpi_pattern_src.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/vpi_pattern_src_pkg.sv
// Shared types and helpers for the VPI pattern source: FSM states, LFSR
// polynomial and word-count arithmetic.
package vpi_pattern_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      PRESENT,
      WAIT_LO,
      DONE
   } state_t;

   localparam logic [31:0] LFSR_MASK  = 32'hA300_0000;
   localparam int          MAX_LENGTH = 128;

   function automatic int nwords(input int len);
      return (len + 31) / 32;
   endfunction

   // Galois right-shift step: shift out bit 0 and fold it back through the mask.
   function automatic logic [31:0] lfsr_step(input logic [31:0] l);
      return l[0] ? ((l >> 1) ^ LFSR_MASK) : (l >> 1);
   endfunction

endpackage

// File: rtl/vpi_pattern_src_if.sv
// Handshake bundle between the pattern source and the VPI-side reader.
// The source drives sig/rfr/valid/seq/done; the reader drives en/ack/err_inject.
interface vpi_pattern_src_if #(
   parameter int LENGTH = 32
) ();

   logic              en;
   logic              ack;
   logic              err_inject;
   logic [LENGTH-1:0] sig;
   logic [LENGTH-1:0] rfr;
   logic              valid;
   logic [31:0]       seq;
   logic              done;

   modport master (
      input  en, ack, err_inject,
      output sig, rfr, valid, seq, done
   );

   modport slave (
      output en, ack, err_inject,
      input  sig, rfr, valid, seq, done
   );

endinterface

// File: rtl/vpi_pattern_src_lfsr.sv
// 32-bit Galois LFSR; `word` is the value the register takes on its next step.
// A zero seed would lock the register, so it is replaced by 1.
module vpi_lfsr32
   import vpi_pattern_pkg::*;
#(
   parameter logic [31:0] SEED = 32'h1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        step,
   output logic [31:0] word
);

   localparam logic [31:0] SEED_EFF = (SEED == 32'h0) ? 32'h1 : SEED;

   logic [31:0] state;

   assign word = lfsr_step(state);

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= SEED_EFF;
      end else if (step) begin
         state <= word;
      end
   end

endmodule

// File: rtl/vpi_pattern_src.sv
// Pattern source: assembles LENGTH-bit pseudo-random values from LFSR words and
// publishes them under a four-phase valid/ack handshake until COUNT are read.
module vpi_pattern_src
   import vpi_pattern_pkg::*;
#(
   parameter int          LENGTH = 32,
   parameter logic [31:0] SEED   = 32'h1,
   parameter int          COUNT  = 16
) (
   input logic               clk,
   input logic               rst,
   vpi_pattern_src_if.master bus
);

   localparam int NW = nwords(LENGTH);
   localparam int BW = NW * 32;

   state_t            state;
   logic [1:0]        wcnt;
   logic              inj;
   logic [BW-1:0]     bld;
   logic [BW-1:0]     bld_nxt;
   logic [31:0]       word;
   logic              step;
   logic              last;
   logic              flip;
   logic [LENGTH-1:0] sig_new;

   vpi_lfsr32 #(
      .SEED(SEED)
   ) u_lfsr (
      .clk (clk),
      .rst (rst),
      .step(step),
      .word(word)
   );

   assign step = (state == LOAD);
   assign last = (wcnt == 2'(NW - 1));
   // An injection request arriving on the final LOAD cycle still hits this value.
   assign flip = inj | bus.err_inject;

   always_comb begin
      bld_nxt = bld;
      for (int k = 0; k < NW; k++) begin
         if (wcnt == 2'(k)) begin
            bld_nxt[k*32 +: 32] = word;
         end
      end
   end

   assign sig_new = bld_nxt[LENGTH-1:0];

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         wcnt      <= 2'd0;
         inj       <= 1'b0;
         bus.sig   <= '0;
         bus.rfr   <= '0;
         bus.valid <= 1'b0;
         bus.seq   <= 32'd0;
         bus.done  <= 1'b0;
      end else begin
         if (bus.err_inject) begin
            inj <= 1'b1;
         end
         case (state)
            IDLE: begin
               if (bus.en) begin
                  wcnt  <= 2'd0;
                  state <= LOAD;
               end
            end
            LOAD: begin
               bld <= bld_nxt;
               if (last) begin
                  bus.sig   <= sig_new;
                  bus.rfr   <= sig_new ^ LENGTH'(flip);
                  inj       <= 1'b0;
                  bus.valid <= 1'b1;
                  state     <= PRESENT;
               end else begin
                  wcnt <= wcnt + 2'd1;
               end
            end
            PRESENT: begin
               if (bus.ack) begin
                  bus.valid <= 1'b0;
                  bus.seq   <= bus.seq + 32'd1;
                  state     <= WAIT_LO;
               end
            end
            WAIT_LO: begin
               if (!bus.ack) begin
                  if (bus.seq == 32'(COUNT)) begin
                     bus.done <= 1'b1;
                     state    <= DONE;
                  end else if (bus.en) begin
                     wcnt  <= 2'd0;
                     state <= LOAD;
                  end else begin
                     state <= IDLE;
                  end
               end
            end
            DONE: begin
               bus.done <= 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_vpi_pattern_src.sv
// Bench for vpi_pattern_src: a cycle table on a LENGTH=32/COUNT=3 instance, plus
// randomized traffic on several widths checked against a transaction-level model.
module tb_vpi_pattern_src;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] lstep(input logic [31:0] l);
      logic lsb;
      lsb = l[0];
      l   = l >> 1;
      if (lsb) l = l ^ 32'hA300_0000;
      return l;
   endfunction

   // Directed instance
   vpi_pattern_src_if #(.LENGTH(32)) ifa ();
   vpi_pattern_src #(.LENGTH(32), .SEED(32'h1), .COUNT(3)) dut_a (
      .clk(clk), .rst(rst), .bus(ifa)
   );

   typedef struct {
      logic        en, ack, inj;
      logic        valid;
      logic [31:0] seq, sig, rfr;
      logic        done;
   } vec_t;

   function automatic vec_t mk(input logic en, input logic ack, input logic inj,
                               input logic valid, input logic [31:0] seq,
                               input logic [31:0] sig, input logic [31:0] rfr,
                               input logic done);
      vec_t v;
      v.en = en; v.ack = ack; v.inj = inj; v.valid = valid;
      v.seq = seq; v.sig = sig; v.rfr = rfr; v.done = done;
      return v;
   endfunction

   // Randomized instances sharing en/err_inject, each with its own ack source
   localparam int NL = 6;
   localparam int LENS [NL] = '{1, 8, 33, 64, 96, 128};

   logic en_r  = 1'b0;
   logic inj_r = 1'b0;
   bit   rnd_on = 1'b0;

   genvar gi;
   generate
      for (gi = 0; gi < NL; gi++) begin : g_len
         localparam int L  = LENS[gi];
         localparam int NW = (L + 31) / 32;

         vpi_pattern_src_if #(.LENGTH(L)) ifr ();
         vpi_pattern_src #(.LENGTH(L), .SEED(32'h1), .COUNT(60000)) dut (
            .clk(clk), .rst(rst), .bus(ifr)
         );

         assign ifr.en         = en_r;
         assign ifr.err_inject = inj_r;

         initial begin
            ifr.ack = 1'b0;
            forever begin
               @(negedge clk);
               ifr.ack = rnd_on ? 1'($urandom_range(0, 1)) : 1'b0;
            end
         end

         // Model: values are consecutive NW-word groups of the LFSR stream;
         // any err_inject sample since the previous value flips bit 0 of rfr.
         logic [31:0]  m_lfsr;
         logic         m_inj;
         logic [31:0]  m_seq;
         logic         prev_v;
         logic [127:0] m_v;
         logic [L-1:0] held;

         always @(posedge clk) begin
            if (rst) begin
               m_lfsr = 32'h1;
               m_inj  = 1'b0;
               m_seq  = 32'd0;
               prev_v = 1'b0;
               #1;
               chk($sformatf("rst%0d.valid", L), ifr.valid, 1'b0);
               chk($sformatf("rst%0d.seq", L), ifr.seq, 32'd0);
               chk($sformatf("rst%0d.sig", L), ifr.sig, '0);
               chk($sformatf("rst%0d.rfr", L), ifr.rfr, '0);
            end else begin
               m_inj = m_inj | inj_r;
               #1;
               if (ifr.valid && !prev_v) begin
                  m_v = '0;
                  for (int k = 0; k < NW; k++) begin
                     m_lfsr = lstep(m_lfsr);
                     m_v[k*32 +: 32] = m_lfsr;
                  end
                  held = m_v[L-1:0];
                  chk($sformatf("len%0d.sig", L), ifr.sig, held);
                  chk($sformatf("len%0d.rfr", L), ifr.rfr, held ^ L'(m_inj));
                  chk($sformatf("len%0d.seq_pres", L), ifr.seq, m_seq);
                  m_inj = 1'b0;
               end else if (!ifr.valid && prev_v) begin
                  m_seq = m_seq + 32'd1;
                  chk($sformatf("len%0d.seq", L), ifr.seq, m_seq);
               end else if (ifr.valid) begin
                  chk($sformatf("len%0d.hold", L), ifr.sig, held);
               end
               prev_v = ifr.valid;
            end
         end
      end
   endgenerate

   vec_t tv [17];
   int   lat64, lat96, lat32;

   initial begin
      tv[0]  = mk(1, 0, 0, 0, 0, 32'h0,         32'h0,         0);
      tv[1]  = mk(0, 0, 0, 1, 0, 32'hA300_0000, 32'hA300_0000, 0);
      tv[2]  = mk(0, 0, 1, 1, 0, 32'hA300_0000, 32'hA300_0000, 0);
      tv[3]  = mk(0, 1, 0, 0, 1, 32'hA300_0000, 32'hA300_0000, 0);
      tv[4]  = mk(1, 1, 0, 0, 1, 32'hA300_0000, 32'hA300_0000, 0);
      tv[5]  = mk(1, 0, 0, 0, 1, 32'hA300_0000, 32'hA300_0000, 0);
      tv[6]  = mk(0, 0, 0, 1, 1, 32'h5180_0000, 32'h5180_0001, 0);
      tv[7]  = mk(0, 1, 0, 0, 2, 32'h5180_0000, 32'h5180_0001, 0);
      tv[8]  = mk(0, 0, 0, 0, 2, 32'h5180_0000, 32'h5180_0001, 0);
      tv[9]  = mk(0, 0, 0, 0, 2, 32'h5180_0000, 32'h5180_0001, 0);
      tv[10] = mk(1, 1, 0, 0, 2, 32'h5180_0000, 32'h5180_0001, 0);
      tv[11] = mk(0, 1, 0, 1, 2, 32'h28C0_0000, 32'h28C0_0000, 0);
      tv[12] = mk(0, 1, 0, 0, 3, 32'h28C0_0000, 32'h28C0_0000, 0);
      tv[13] = mk(1, 1, 0, 0, 3, 32'h28C0_0000, 32'h28C0_0000, 0);
      tv[14] = mk(1, 0, 0, 0, 3, 32'h28C0_0000, 32'h28C0_0000, 1);
      tv[15] = mk(1, 1, 0, 0, 3, 32'h28C0_0000, 32'h28C0_0000, 1);
      tv[16] = mk(1, 0, 1, 0, 3, 32'h28C0_0000, 32'h28C0_0000, 1);

      rst = 1'b1;
      ifa.en = 1'b0; ifa.ack = 1'b0; ifa.err_inject = 1'b0;
      @(posedge clk); #1;
      chk("a_rst.valid", ifa.valid, 1'b0);
      chk("a_rst.seq",   ifa.seq,   32'd0);
      chk("a_rst.sig",   ifa.sig,   32'd0);
      chk("a_rst.rfr",   ifa.rfr,   32'd0);
      chk("a_rst.done",  ifa.done,  1'b0);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 17; i++) begin
         ifa.en = tv[i].en; ifa.ack = tv[i].ack; ifa.err_inject = tv[i].inj;
         @(posedge clk); #1;
         chk($sformatf("vec%0d.valid", i), ifa.valid, tv[i].valid);
         chk($sformatf("vec%0d.seq", i),   ifa.seq,   tv[i].seq);
         chk($sformatf("vec%0d.sig", i),   ifa.sig,   tv[i].sig);
         chk($sformatf("vec%0d.rfr", i),   ifa.rfr,   tv[i].rfr);
         chk($sformatf("vec%0d.done", i),  ifa.done,  tv[i].done);
         @(negedge clk);
      end
      ifa.en = 1'b0; ifa.ack = 1'b0; ifa.err_inject = 1'b0;

      // Reset out of DONE, start a value, then reset during PRESENT
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0; ifa.en = 1'b1;
      @(negedge clk);
      ifa.en = 1'b0;
      @(negedge clk);
      chk("a_pres.valid", ifa.valid, 1'b1);
      rst = 1'b1;
      @(posedge clk); #1;
      chk("a_rstp.valid", ifa.valid, 1'b0);
      chk("a_rstp.sig",   ifa.sig,   32'd0);
      chk("a_rstp.done",  ifa.done,  1'b0);
      @(negedge clk);
      rst = 1'b0; ifa.en = 1'b1;
      lat32 = 0;
      for (int n = 1; n <= 10; n++) begin
         @(negedge clk);
         ifa.en = 1'b0;
         if (ifa.valid && lat32 == 0) lat32 = n;
      end
      chk("a_lat", 32'(lat32), 32'd2);
      chk("a_reseed.sig", ifa.sig, 32'hA300_0000);

      // Reset the wide instances mid-LOAD, then measure first-value latency
      en_r = 1'b1;
      @(negedge clk);
      en_r = 1'b0; rst = 1'b1;
      @(posedge clk); #1;
      chk("w96_rstload.valid", g_len[4].ifr.valid, 1'b0);
      chk("w96_rstload.sig",   g_len[4].ifr.sig,   96'h0);
      @(negedge clk);
      rst = 1'b0; en_r = 1'b1;
      lat64 = 0; lat96 = 0;
      for (int n = 1; n <= 10; n++) begin
         @(negedge clk);
         en_r = 1'b0;
         if (g_len[3].ifr.valid && lat64 == 0) lat64 = n;
         if (g_len[4].ifr.valid && lat96 == 0) lat96 = n;
      end
      chk("w64_lat", 32'(lat64), 32'd3);
      chk("w96_lat", 32'(lat96), 32'd4);
      chk("w64_first", g_len[3].ifr.sig, 64'h5180_0000_A300_0000);
      chk("w96_first", g_len[4].ifr.sig, 96'h28C0_0000_5180_0000_A300_0000);

      rnd_on = 1'b1;
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         en_r  = ($urandom_range(0, 3) != 0);
         inj_r = ($urandom_range(0, 15) == 0);
         rst   = (c == 1500);
      end
      @(negedge clk);
      rnd_on = 1'b0; en_r = 1'b0; inj_r = 1'b0; rst = 1'b0;
      repeat (3) @(negedge clk);
      chk("progress128", 32'(g_len[5].m_seq != 32'd0), 32'd1);
      chk("progress1",   32'(g_len[0].m_seq != 32'd0), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
